// File: rtl/gray_counter_gen.sv
// Prescaled up/down Gray counter with wrap/saturate, clear, terminal-count pulse and binary shadow.
// Latency: step lands on gray_code/bin_code/tick/tc at the same edge; no backpressure (free-running).
// Optional load port set (load_valid/load_gray) is built only when GRAY_CNT_LOAD_EN is defined.
module gray_counter_gen #(
    parameter int WIDTH        = 4,
    parameter int PRESCALE_DIV = 100_000_000,
    parameter bit SATURATE     = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_down,
    input  logic             clear,
`ifdef GRAY_CNT_LOAD_EN
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_gray,
`endif
    output logic [WIDTH-1:0] gray_code,
    output logic [WIDTH-1:0] bin_code,
    output logic             tick,
    output logic             tc
);

    localparam int               PS_W     = ($clog2(PRESCALE_DIV) > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE_DIV - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [PS_W-1:0]  ps_cnt;
    logic             step_due;
    logic             at_limit;
    logic [WIDTH-1:0] bin_step;
    logic [WIDTH-1:0] bin_next;
    logic             tc_next;

    assign step_due = en && (ps_cnt == PS_LAST);

    always_comb begin
        at_limit = up_down ? (bin_code == ALL_ONES) : (bin_code == '0);
        bin_step = up_down ? bin_code + WIDTH'(1) : bin_code - WIDTH'(1);
        bin_next = bin_step;
        tc_next  = at_limit;
        if (SATURATE) begin
            // Pulse only when arriving at the limit; holding there is silent.
            bin_next = at_limit ? bin_code : bin_step;
            tc_next  = !at_limit && (up_down ? (bin_step == ALL_ONES) : (bin_step == '0));
        end
    end

`ifdef GRAY_CNT_LOAD_EN
    logic [WIDTH-1:0] load_bin;

    // Bit i of the binary value is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        load_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            load_bin[i] = ^(load_gray >> i);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_cnt    <= '0;
            bin_code  <= '0;
            gray_code <= '0;
            tick      <= 1'b0;
            tc        <= 1'b0;
        end else if (clear) begin
            ps_cnt    <= '0;
            bin_code  <= '0;
            gray_code <= '0;
            tick      <= 1'b0;
            tc        <= 1'b0;
`ifdef GRAY_CNT_LOAD_EN
        end else if (load_valid) begin
            ps_cnt    <= '0;
            bin_code  <= load_bin;
            gray_code <= load_gray;
            tick      <= 1'b0;
            tc        <= 1'b0;
`endif
        end else begin
            tick <= step_due;
            tc   <= step_due && tc_next;
            if (en) begin
                ps_cnt <= (ps_cnt == PS_LAST) ? '0 : ps_cnt + PS_W'(1);
            end
            if (step_due) begin
                bin_code  <= bin_next;
                gray_code <= bin_next ^ (bin_next >> 1);
            end
        end
    end

endmodule
